// File: rtl/feed_sink_if.sv
// feed_sink bus port: four-phase request/ready responder bundle.
// The DMA engine or CPU is the master; feed_sink is the slave.
interface feed_sink_if;
  logic        i_request;
  logic        i_rw;
  logic [1:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;

  modport master (
    output i_request,
    output i_rw,
    output i_address,
    output i_wdata,
    input  o_rdata,
    input  o_ready
  );

  modport slave (
    input  i_request,
    input  i_rw,
    input  i_address,
    input  i_wdata,
    output o_rdata,
    output o_ready
  );
endinterface

// File: rtl/feed_sink.sv
// feed_sink: bus write sink -> FIFO -> valid/ready stream, with status/counters.
// FEED_SINK_WATERMARK_EN adds a watermark register and o_low_water output.
module feed_sink #(
  parameter int DEPTH   = 64,
  parameter int LEVEL_W = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  feed_sink_if.slave  bus,
  output logic        o_stream_valid,
  output logic [31:0] o_stream_data,
  input  logic        i_stream_ready
`ifdef FEED_SINK_WATERMARK_EN
  ,
  output logic        o_low_water
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic [31:0]        acc_q, con_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               unr_q;

  logic full, empty, accept, wr;
  logic push, pop, flush, clr_unr, set_unr;
  logic [31:0] status, reg3;

`ifdef FEED_SINK_WATERMARK_EN
  logic [LEVEL_W-1:0] wm_q;
  logic               lw_q;
  assign reg3 = 32'(wm_q);
  assign o_low_water = lw_q;
`else
  assign reg3 = 32'(DEPTH);
`endif

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign wr      = accept && bus.i_rw;
  assign push    = wr && (bus.i_address == 2'd0);
  assign flush   = wr && (bus.i_address == 2'd1) && bus.i_wdata[0];
  assign clr_unr = wr && (bus.i_address == 2'd1) && bus.i_wdata[1];
  assign pop     = o_stream_valid && i_stream_ready;
  assign set_unr = i_stream_ready && empty;

  assign status = {16'(level_q), 13'b0, unr_q, full, empty};

  assign o_stream_valid = !empty;
  assign o_stream_data  = empty ? '0 : mem[rptr_q];
  assign bus.o_ready    = (state_q == S_ACK);
  assign bus.o_rdata    = rdata_q;

  // Full uses the registered level: a same-cycle pop frees space next cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_request &&
            !(bus.i_rw && bus.i_address == 2'd0 && full)) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!bus.i_request)
          state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == S_ACK && !bus.i_request) begin
      rdata_d = '0;
    end else if (accept && !bus.i_rw) begin
      unique case (bus.i_address)
        2'd0: rdata_d = acc_q;
        2'd1: rdata_d = status;
        2'd2: rdata_d = con_q;
        2'd3: rdata_d = reg3;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push)
      mem[wptr_q] <= bus.i_wdata;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        level_q <= level_q + 1'b1;
      else if (pop && !push)
        level_q <= level_q - 1'b1;
    end
  end

  // Consumed counts every pop, including one that a flush overrides.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc_q <= '0;
      con_q <= '0;
      unr_q <= 1'b0;
    end else begin
      if (push)
        acc_q <= acc_q + 32'd1;
      if (pop)
        con_q <= con_q + 32'd1;
      if (set_unr)
        unr_q <= 1'b1;
      else if (clr_unr)
        unr_q <= 1'b0;
    end
  end

`ifdef FEED_SINK_WATERMARK_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wm_q <= LEVEL_W'(DEPTH / 4);
      lw_q <= 1'b0;
    end else begin
      if (wr && bus.i_address == 2'd3)
        wm_q <= bus.i_wdata[LEVEL_W-1:0];
      lw_q <= (level_q <= wm_q);
    end
  end
`endif

endmodule

// File: tb/tb_feed_sink.sv
// tb_feed_sink: scoreboard bench for feed_sink.
// Bus writes push expected stream words; the stream monitor pops/compares.
module tb_feed_sink;

  logic        i_clock;
  logic        i_reset;
  logic        o_stream_valid;
  logic [31:0] o_stream_data;
  logic        i_stream_ready;
`ifdef FEED_SINK_WATERMARK_EN
  logic        o_low_water;
`endif

  feed_sink_if bus ();

  feed_sink #(.DEPTH(64), .LEVEL_W(16)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .bus            (bus),
    .o_stream_valid (o_stream_valid),
    .o_stream_data  (o_stream_data),
    .i_stream_ready (i_stream_ready)
`ifdef FEED_SINK_WATERMARK_EN
    ,
    .o_low_water    (o_low_water)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_acc = 0;
  logic [31:0] exp_con = 0;
  logic [31:0] rd;
  int lat;

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; returns at a negedge with request dropped.
  task automatic bus_xfer(input logic rw, input logic [1:0] a,
                          input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc);
    bus.i_request = 1'b1;
    bus.i_rw      = rw;
    bus.i_address = a;
    bus.i_wdata   = d;
    cyc   = 0;
    rdata = '0;
    do begin
      @(negedge i_clock);
      cyc++;
    end while (!bus.o_ready && cyc < 200);
    if (!bus.o_ready) begin
      check("bus_timeout", 32'(bus.o_ready), 32'd1);
    end else begin
      rdata = bus.o_rdata;
      if (rw && a == 2'd0) begin
        sb.push_back(d);
        exp_acc++;
      end
    end
    bus.i_request = 1'b0;
    @(negedge i_clock);
    check("ready_fall", 32'(bus.o_ready), 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    int c;
    bus_xfer(1'b0, a, 32'd0, v, c);
    check(tag, v, exp);
  endtask

  always @(negedge i_clock) begin
    #2;
    if (i_reset && o_stream_valid && i_stream_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", o_stream_data, 32'hxxxx_xxxx);
      end else begin
        check("stream", o_stream_data, sb.pop_front());
      end
      exp_con++;
    end
  end

  initial begin
    i_reset        = 1'b0;
    i_stream_ready = 1'b0;
    bus.i_request  = 1'b0;
    bus.i_rw       = 1'b0;
    bus.i_address  = '0;
    bus.i_wdata    = '0;
    #12;
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_valid", 32'(o_stream_valid), 32'd0);
    check("rst_data", o_stream_data, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;

    rd_chk("stat_empty", 2'd1, 32'h0000_0001);
`ifdef FEED_SINK_WATERMARK_EN
    rd_chk("reg3", 2'd3, 32'd16);
`else
    rd_chk("reg3", 2'd3, 32'd64);
`endif

    bus_xfer(1'b1, 2'd0, 32'hA5A5_0001, rd, lat);
    check("wr_lat", 32'(lat), 32'd1);
    check("head_valid", 32'(o_stream_valid), 32'd1);
    check("head_data", o_stream_data, 32'hA5A5_0001);
    rd_chk("stat_one", 2'd1, 32'h0001_0000);

    for (int i = 1; i < 64; i++)
      bus_xfer(1'b1, 2'd0, 32'hA5A5_0001 + 32'(i), rd, lat);
    rd_chk("stat_full", 2'd1, 32'h0040_0002);

    fork
      bus_xfer(1'b1, 2'd0, 32'hA5A5_0041, rd, lat);
      begin
        repeat (5) begin
          @(negedge i_clock);
          check("stall", 32'(bus.o_ready), 32'd0);
        end
        i_stream_ready = 1'b1;
        @(negedge i_clock);
        i_stream_ready = 1'b0;
      end
    join
    check("stall_lat", 32'(lat), 32'd7);
    rd_chk("acc_65", 2'd0, 32'd65);
    rd_chk("con_1", 2'd2, 32'd1);

    i_stream_ready = 1'b1;
    for (int i = 0; i < 100 && o_stream_valid; i++)
      @(negedge i_clock);
    @(negedge i_clock);
    i_stream_ready = 1'b0;
    check("drained", 32'(sb.size()), 32'd0);
    rd_chk("stat_unr", 2'd1, 32'h0000_0005);
    rd_chk("con_65", 2'd2, exp_con);
    bus_xfer(1'b1, 2'd1, 32'h0000_0002, rd, lat);
    rd_chk("stat_clr", 2'd1, 32'h0000_0001);

    for (int i = 0; i < 10; i++)
      bus_xfer(1'b1, 2'd0, 32'h0000_1000 + 32'(i), rd, lat);
    rd_chk("stat_ten", 2'd1, 32'h000A_0000);
    fork
      bus_xfer(1'b1, 2'd1, 32'h0000_0001, rd, lat);
      begin
        i_stream_ready = 1'b1;
        @(negedge i_clock);
        i_stream_ready = 1'b0;
        check("flush_valid", 32'(o_stream_valid), 32'd0);
      end
    join
    sb.delete();
    rd_chk("stat_flush", 2'd1, 32'h0000_0001);
    rd_chk("con_flush", 2'd2, 32'd66);
    rd_chk("acc_75", 2'd0, exp_acc);

    for (int i = 0; i < 64; i++)
      bus_xfer(1'b1, 2'd0, 32'h0000_2000 + 32'(i), rd, lat);
    bus.i_request = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = 2'd0;
    bus.i_wdata   = 32'hDEAD_0000;
    repeat (3) begin
      @(negedge i_clock);
      check("rst_stall", 32'(bus.o_ready), 32'd0);
    end
    i_reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.o_ready), 32'd0);
    check("mid_rst_valid", 32'(o_stream_valid), 32'd0);
    check("mid_rst_data", o_stream_data, 32'd0);
    bus.i_request = 1'b0;
    sb.delete();
    exp_acc = 0;
    exp_con = 0;
    @(negedge i_clock);
    i_reset = 1'b1;
    bus_xfer(1'b1, 2'd0, 32'hBEEF_0001, rd, lat);
    check("rerq_lat", 32'(lat), 32'd1);
    rd_chk("acc_rst", 2'd0, 32'd1);
    rd_chk("con_rst", 2'd2, 32'd0);
    rd_chk("stat_rst", 2'd1, 32'h0001_0000);

    i_stream_ready = 1'b1;
    for (int i = 0; i < 10 && o_stream_valid; i++)
      @(negedge i_clock);
    i_stream_ready = 1'b0;
    check("final_sb", 32'(sb.size()), 32'd0);
    check("final_con", exp_con, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
